mb_r4_pipe_mac: RTL and testbench
=================================

# mb_r4_pipe_mac

Parametrised, fully pipelined radix-4 modified-Booth multiply-accumulate unit for the systolic multiplier array. Each cycle it accepts one operand pair with a signed/unsigned mode and an accumulate flag. It produces the product or running sum after a fixed three-stage latency. Operands are re-registered onto forwarding outputs so tiles chain neighbour-to-neighbour without external flops.

## Interface
- WIDTH, 16, operand width; even, ≥4
- ACC_WIDTH, 40, accumulator/result width; ≥ 2*WIDTH

- CLK  in  1  rising-edge clock
- RST  in  1  reset, synchronous, active-high
- EN  in  1  global clock enable; low freezes every register
- in_valid  in  1  operand pair present
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_acc  in  1  1 = add product to accumulator, 0 = load product
- mx1  in  WIDTH  multiplicand
- my1  in  WIDTH  multiplier
- mx2  out  WIDTH  forwarded multiplicand
- my2  out  WIDTH  forwarded multiplier
- fwd_valid  out  1  mx2/my2 carry a valid pair
- out_valid  out  1  result valid
- result  out  ACC_WIDTH  product or accumulated sum

## Operation
- Booth recoding:
  - my1 is extended by one bit: sign bit if in_signed, 0 otherwise.
  - It is then recoded into NPP = WIDTH/2+1 radix-4 digits in {-2,-1,0,+1,+2}.
  - mx1 is extended the same way to WIDTH+1 bits before selection.
- Partial products are sign-extended to 2*WIDTH and summed. The product is exact modulo 2^(2*WIDTH).
- Product extension to ACC_WIDTH follows the transaction's in_signed: sign extension if 1, zero extension if 0.
- Stage 1, S1:
  - Register operands, mode bits and valid.
  - Generate the NPP partial products combinationally after the register.
- Stage 2, S2: register the carry-save reduction, or an equivalent partial sum, of the partial products plus mode/valid.
- Stage 3, S3: final add, then accumulate:
  - If in_acc, acc ← acc + ext(product), wrapping modulo 2^ACC_WIDTH.
  - Otherwise acc ← ext(product).
  - result = acc.
- acc updates only when S3 receives a valid entry.
- Invalid bubbles pass through without touching acc.
- result holds its last value between valid outputs.
- Forwarding: when EN=1, mx2 ← mx1, my2 ← my1 and fwd_valid ← in_valid. This happens unconditionally every enabled cycle, so a bubble propagates as fwd_valid=0.
- Mode bits travel with their data. Mixed signed/unsigned and acc/load transactions may be issued back-to-back.

## Timing
- Latency: a pair accepted at edge N with EN=1 gives out_valid=1 and result after edge N+3, counting enabled edges only.
- Throughput: one pair per enabled cycle. There is no back-pressure beyond EN.
- EN=0 holds all stage registers, acc, the forwarding registers and the outputs. Inputs presented while EN=0 are ignored.
- Reset, on an edge with RST=1:
  - All valid bits clear: S1/S2/S3, out_valid, fwd_valid.
  - acc=0, result=0, mx2=0, my2=0.
  - Reset takes priority over EN.
- Reset mid-operation: all in-flight entries are discarded. The first valid output after reset comes from a pair accepted on or after the first edge with RST=0.
- in_acc=1 on the first valid transaction after reset accumulates onto 0.
- Boundaries (WIDTH=16):
  - signed −32768 × −32768 = +2^30 is exact.
  - unsigned 0xFFFF × 0xFFFF = 0xFFFE0001 is exact.
  - Accumulator overflow wraps silently, with no saturation and no flag.

## Structure
- Package mb_pkg holds:
  - function npp(width) = width/2+1
  - enum booth_digit_t {ZERO, POS1, POS2, NEG1, NEG2}
  - the stage-count constant MB_LAT = 3
- Sub-module mb_r4_ppgen, combinational, parametrised by WIDTH: takes the extended multiplicand, the multiplier and the signed flag, and produces NPP partial products.
- The reduction tree and the pipeline registers live in mb_r4_pipe_mac.

## Test plan
- WIDTH=16, signed, mx1=0x8000, my1=0x8000, in_acc=0 → after 3 cycles out_valid=1, result=0x0040000000.
- Unsigned 0xFFFF×0xFFFF, then signed 0xFFFF×0xFFFF back-to-back → result 0x00FFFE0001, then 0x0000000001 on consecutive cycles.
- Accumulate sequence:
  - Issue 3×4 (load), then 5×−2 (acc, signed), then 7×7 (acc).
  - Expected results 12, 2, 51.
  - A bubble is inserted between the 2nd and 3rd pairs; acc is unchanged during the bubble.
- Hold EN=0 for 4 cycles with two pairs in flight → outputs, mx2/my2 and acc frozen. Results then appear at the correct enabled-edge count.
- Assert RST for 1 cycle with three valid pairs in flight → out_valid stays 0 for the next 3 cycles. acc=0, mx2=my2=0, fwd_valid=0.
- Random signed/unsigned/acc stream of 10k pairs against a reference model. Also check that mx2/my2 equal the prior-cycle mx1/my1 on every enabled cycle.

Source files
------------

// File: rtl/mb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mb_pkg
// Brief    : Shared types, constants and Booth digit decode for the radix-4 MAC.
// Revision : 1.0 - initial release
// ============================================================================
package mb_pkg;

    // Register stages between operand acceptance and a visible result.
    localparam int MB_LAT = 3;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    function automatic int npp(input int width);
        return width / 2 + 1;
    endfunction

    // Triplet is {y[2i+1], y[2i], y[2i-1]}.
    function automatic booth_digit_t booth_decode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mb_r4_ppgen.sv
`default_nettype none
// ============================================================================
// Module   : mb_r4_ppgen
// Brief    : Radix-4 modified-Booth partial product generator (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module mb_r4_ppgen
    import mb_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NPP   = npp(WIDTH)
) (
    input  logic [WIDTH:0]                 i_mx_ext,
    input  logic [WIDTH-1:0]               i_my,
    input  logic                           i_signed,
    output logic [NPP-1:0][2*WIDTH-1:0]    o_pp
);

    localparam int c_pw = 2 * WIDTH;

    logic            w_my_ext_bit;
    logic [WIDTH+2:0] w_yb;
    logic [c_pw-1:0] w_xe;

    // Multiplier gets its extension bit plus one more copy so the top digit
    // sees a full triplet; bit 0 is the implicit y[-1] = 0.
    assign w_my_ext_bit = i_signed & i_my[WIDTH-1];
    assign w_yb         = {w_my_ext_bit, w_my_ext_bit, i_my, 1'b0};
    assign w_xe         = {{(c_pw-WIDTH-1){i_mx_ext[WIDTH]}}, i_mx_ext};

    for (genvar i = 0; i < NPP; i++) begin : g_pp
        booth_digit_t    w_dig;
        logic [c_pw-1:0] w_mag;
        logic [c_pw-1:0] w_term;

        assign w_dig = booth_decode(w_yb[2*i +: 3]);

        always_comb begin
            case (w_dig)
                POS1, NEG1: w_mag = w_xe;
                POS2, NEG2: w_mag = w_xe << 1;
                default:    w_mag = '0;
            endcase
        end

        assign w_term  = (w_dig == NEG1 || w_dig == NEG2) ? -w_mag : w_mag;
        assign o_pp[i] = w_term << (2 * i);
    end

endmodule
`default_nettype wire

// File: rtl/mb_r4_pipe_mac.sv
`default_nettype none
// ============================================================================
// Module   : mb_r4_pipe_mac
// Brief    : Pipelined radix-4 Booth multiply-accumulate tile with operand forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module mb_r4_pipe_mac
    import mb_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 in_valid,
    input  logic                 in_signed,
    input  logic                 in_acc,
    input  logic [WIDTH-1:0]     mx1,
    input  logic [WIDTH-1:0]     my1,
    output logic [WIDTH-1:0]     mx2,
    output logic [WIDTH-1:0]     my2,
    output logic                 fwd_valid,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] result
);

    localparam int c_npp = npp(WIDTH);
    localparam int c_pw  = 2 * WIDTH;

    // Forwarding registers
    logic [WIDTH-1:0] r_mx2;
    logic [WIDTH-1:0] r_my2;
    logic             r_fwd_valid;

    // S1: operands and mode bits
    logic             r_s1_valid;
    logic             r_s1_signed;
    logic             r_s1_acc;
    logic [WIDTH-1:0] r_s1_mx;
    logic [WIDTH-1:0] r_s1_my;

    // S2: carry-save pair
    logic             r_s2_valid;
    logic             r_s2_signed;
    logic             r_s2_acc;
    logic [c_pw-1:0]  r_s2_sum;
    logic [c_pw-1:0]  r_s2_carry;

    // S3: resolved, extended product
    logic                 r_s3_valid;
    logic                 r_s3_acc;
    logic [ACC_WIDTH-1:0] r_s3_prod;

    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_acc;

    logic [WIDTH:0]                  w_mx_ext;
    logic [c_npp-1:0][c_pw-1:0]      w_pp;
    logic [c_pw-1:0]                 w_cs_sum;
    logic [c_pw-1:0]                 w_cs_carry;
    logic [c_pw-1:0]                 w_prod;
    logic [ACC_WIDTH-1:0]            w_prod_ext;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mx2       <= '0;
            r_my2       <= '0;
            r_fwd_valid <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_signed <= 1'b0;
            r_s1_acc    <= 1'b0;
            r_s1_mx     <= '0;
            r_s1_my     <= '0;
        end else if (EN) begin
            r_mx2       <= mx1;
            r_my2       <= my1;
            r_fwd_valid <= in_valid;
            r_s1_valid  <= in_valid;
            r_s1_signed <= in_signed;
            r_s1_acc    <= in_acc;
            r_s1_mx     <= mx1;
            r_s1_my     <= my1;
        end
    end

    assign w_mx_ext = {r_s1_signed & r_s1_mx[WIDTH-1], r_s1_mx};

    mb_r4_ppgen #(
        .WIDTH (WIDTH),
        .NPP   (c_npp)
    ) u_ppgen (
        .i_mx_ext (w_mx_ext),
        .i_my     (r_s1_my),
        .i_signed (r_s1_signed),
        .o_pp     (w_pp)
    );

    // Linear 3:2 compressor chain; all arithmetic is modulo 2^(2*WIDTH).
    always_comb begin : p_csa
        logic [c_pw-1:0] v_s;
        logic [c_pw-1:0] v_c;
        logic [c_pw-1:0] v_t;
        v_s = w_pp[0];
        v_c = w_pp[1];
        v_t = '0;
        for (int i = 2; i < c_npp; i++) begin
            v_t = v_s ^ v_c ^ w_pp[i];
            v_c = ((v_s & v_c) | (v_s & w_pp[i]) | (v_c & w_pp[i])) << 1;
            v_s = v_t;
        end
        w_cs_sum   = v_s;
        w_cs_carry = v_c;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid  <= 1'b0;
            r_s2_signed <= 1'b0;
            r_s2_acc    <= 1'b0;
            r_s2_sum    <= '0;
            r_s2_carry  <= '0;
        end else if (EN) begin
            r_s2_valid  <= r_s1_valid;
            r_s2_signed <= r_s1_signed;
            r_s2_acc    <= r_s1_acc;
            r_s2_sum    <= w_cs_sum;
            r_s2_carry  <= w_cs_carry;
        end
    end

    assign w_prod = r_s2_sum + r_s2_carry;

    if (ACC_WIDTH > c_pw) begin : g_ext
        assign w_prod_ext = {{(ACC_WIDTH-c_pw){r_s2_signed & w_prod[c_pw-1]}}, w_prod};
    end else begin : g_noext
        assign w_prod_ext = w_prod;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s3_valid <= 1'b0;
            r_s3_acc   <= 1'b0;
            r_s3_prod  <= '0;
        end else if (EN) begin
            r_s3_valid <= r_s2_valid;
            r_s3_acc   <= r_s2_acc;
            r_s3_prod  <= w_prod_ext;
        end
    end

    // Bubbles leave the accumulator untouched so result holds between outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
        end else if (EN) begin
            r_out_valid <= r_s3_valid;
            if (r_s3_valid) begin
                r_acc <= r_s3_acc ? (r_acc + r_s3_prod) : r_s3_prod;
            end
        end
    end

    assign mx2       = r_mx2;
    assign my2       = r_my2;
    assign fwd_valid = r_fwd_valid;
    assign out_valid = r_out_valid;
    assign result    = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mb_r4_pipe_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_mb_r4_pipe_mac
// Brief    : Self-checking bench: directed vectors, corner sequences, random stream vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mb_r4_pipe_mac;
    import mb_pkg::*;

    localparam int W  = 16;
    localparam int AW = 40;

    logic          CLK = 1'b0;
    logic          RST;
    logic          EN;
    logic          in_valid;
    logic          in_signed;
    logic          in_acc;
    logic [W-1:0]  mx1;
    logic [W-1:0]  my1;
    logic [W-1:0]  mx2;
    logic [W-1:0]  my2;
    logic          fwd_valid;
    logic          out_valid;
    logic [AW-1:0] result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic          sgn;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    mb_r4_pipe_mac #(
        .WIDTH     (W),
        .ACC_WIDTH (AW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .in_valid  (in_valid),
        .in_signed (in_signed),
        .in_acc    (in_acc),
        .mx1       (mx1),
        .my1       (my1),
        .mx2       (mx2),
        .my2       (my2),
        .fwd_valid (fwd_valid),
        .out_valid (out_valid),
        .result    (result)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact product by plain integer arithmetic, reduced to accumulator width.
    function automatic logic [AW-1:0] ref_prod(input logic s, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint a;
        longint b;
        a = s ? longint'($signed(x)) : longint'(x);
        b = s ? longint'($signed(y)) : longint'(y);
        return AW'(a * b);
    endfunction

    // Reference: acc is updated at acceptance; the value then travels down a
    // delay line of MB_LAT enabled edges before becoming visible.
    logic [MB_LAT-1:0] m_v;
    logic [AW-1:0]     m_val [MB_LAT];
    logic [AW-1:0]     m_acc;
    logic              exp_ov;
    logic [AW-1:0]     exp_res;
    logic [W-1:0]      exp_mx2;
    logic [W-1:0]      exp_my2;
    logic              exp_fv;

    always @(posedge CLK) begin : model
        logic [AW-1:0] nacc;
        nacc = m_acc;
        if (RST) begin
            m_v     <= '0;
            m_acc   <= '0;
            exp_ov  <= 1'b0;
            exp_res <= '0;
            exp_mx2 <= '0;
            exp_my2 <= '0;
            exp_fv  <= 1'b0;
        end else if (EN) begin
            exp_ov <= m_v[MB_LAT-1];
            if (m_v[MB_LAT-1]) exp_res <= m_val[MB_LAT-1];
            if (in_valid) begin
                nacc  = ref_prod(in_signed, mx1, my1) + (in_acc ? m_acc : '0);
                m_acc <= nacc;
            end
            m_v      <= {m_v[MB_LAT-2:0], in_valid};
            m_val[0] <= nacc;
            for (int k = 1; k < MB_LAT; k++) m_val[k] <= m_val[k-1];
            exp_mx2 <= mx1;
            exp_my2 <= my1;
            exp_fv  <= in_valid;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("mdl out_valid", 64'(out_valid), 64'(exp_ov));
            check("mdl result",    64'(result),    64'(exp_res));
            check("mdl mx2",       64'(mx2),       64'(exp_mx2));
            check("mdl my2",       64'(my2),       64'(exp_my2));
            check("mdl fwd_valid", 64'(fwd_valid), 64'(exp_fv));
        end
    end

    task automatic drive(input logic v, input logic s, input logic a,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge CLK);
        in_valid  = v;
        in_signed = s;
        in_acc    = a;
        mx1       = x;
        my1       = y;
    endtask

    logic [W-1:0] corners [4];

    initial begin
        RST = 1'b1; EN = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_acc = 1'b0;
        mx1 = '0; my1 = '0;
        corners = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF};

        vecs[0] = '{1'b1, 16'h8000, 16'h8000, 40'h0040000000};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 40'h00FFFE0001};
        vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 40'h0000000001};
        vecs[3] = '{1'b1, 16'h7FFF, 16'h8000, 40'hFFC0008000};
        vecs[4] = '{1'b0, 16'h8000, 16'h8000, 40'h0040000000};
        vecs[5] = '{1'b1, 16'hFFFF, 16'h0002, 40'hFFFFFFFFFE};
        vecs[6] = '{1'b0, 16'hFFFF, 16'h0002, 40'h000001FFFE};
        vecs[7] = '{1'b0, 16'h1234, 16'h0010, 40'h0000012340};
        vecs[8] = '{1'b1, 16'h0000, 16'h8000, 40'h0000000000};
        vecs[9] = '{1'b1, 16'h7FFF, 16'h7FFF, 40'h003FFF0001};

        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk_en = 1'b1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result",    64'(result),    64'd0);
        check("reset mx2",       64'(mx2),       64'd0);
        check("reset fwd_valid", 64'(fwd_valid), 64'd0);

        // Directed single products (load only)
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].sgn, 1'b0, vecs[i].x, vecs[i].y);
            drive(1'b0, 1'b0, 1'b0, '0, '0);
            repeat (MB_LAT) @(negedge CLK);
            check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d result", i),    64'(result),    64'(vecs[i].exp));
        end

        // Mixed-mode back-to-back
        drive(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        drive(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge CLK);
        check("b2b first",  64'(result), 64'h00FFFE0001);
        @(negedge CLK);
        check("b2b second", 64'(result), 64'h0000000001);
        check("b2b second valid", 64'(out_valid), 64'd1);

        // Accumulate with a bubble between the 2nd and 3rd pairs
        drive(1'b1, 1'b1, 1'b0, 16'd3, 16'd4);
        drive(1'b1, 1'b1, 1'b1, 16'd5, 16'hFFFE);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b1, 16'd7, 16'd7);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        check("acc 12", 64'(result), 64'd12);
        @(negedge CLK);
        check("acc 2", 64'(result), 64'd2);
        @(negedge CLK);
        check("acc bubble valid", 64'(out_valid), 64'd0);
        check("acc bubble hold",  64'(result),    64'd2);
        @(negedge CLK);
        check("acc 51", 64'(result), 64'd51);

        // EN held low for four edges with two pairs in flight
        drive(1'b1, 1'b1, 1'b0, 16'd100, 16'hFFFD);
        drive(1'b1, 1'b0, 1'b1, 16'd7, 16'd8);
        drive(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
        EN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check("frz result",    64'(result),    64'd51);
            check("frz out_valid", 64'(out_valid), 64'd0);
            check("frz mx2",       64'(mx2),       64'd7);
            check("frz my2",       64'(my2),       64'd8);
            check("frz fwd_valid", 64'(fwd_valid), 64'd1);
        end
        EN = 1'b1;
        in_valid = 1'b0;
        @(negedge CLK);
        check("en early valid", 64'(out_valid), 64'd0);
        @(negedge CLK);
        check("en first",  64'(result), 64'hFFFFFFFED4);
        @(negedge CLK);
        check("en second", 64'(result), 64'hFFFFFFFF0C);

        // Reset with three valid pairs in flight
        drive(1'b1, 1'b1, 1'b0, 16'd3, 16'd3);
        drive(1'b1, 1'b1, 1'b1, 16'd4, 16'd4);
        drive(1'b1, 1'b0, 1'b1, 16'd5, 16'd5);
        drive(1'b1, 1'b1, 1'b0, 16'd9, 16'd9);
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        RST = 1'b0;
        check("rst2 result",    64'(result),    64'd0);
        check("rst2 mx2",       64'(mx2),       64'd0);
        check("rst2 my2",       64'(my2),       64'd0);
        check("rst2 fwd_valid", 64'(fwd_valid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("rst2 out_valid", 64'(out_valid), 64'd0);
            @(negedge CLK);
        end
        drive(1'b1, 1'b1, 1'b1, 16'd6, 16'd7);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (MB_LAT) @(negedge CLK);
        check("acc onto 0", 64'(result), 64'd42);

        // Random stream against the reference model
        for (int n = 0; n < 10000; ) begin
            @(negedge CLK);
            EN        = ($urandom_range(0, 9) != 0);
            RST       = ($urandom_range(0, 499) == 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            in_signed = 1'($urandom);
            in_acc    = 1'($urandom);
            mx1       = W'($urandom);
            my1       = W'($urandom);
            if ($urandom_range(0, 7) == 0) mx1 = corners[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) my1 = corners[$urandom_range(0, 3)];
            if (EN && in_valid && !RST) n++;
        end
        @(negedge CLK);
        RST = 1'b0; EN = 1'b1; in_valid = 1'b0;
        repeat (MB_LAT + 2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
